// File: rtl/pulse_event_queue.sv
// Turns per-field single-cycle pulses into a FIFO-buffered stream of field-index events.
// Pulses park in a pending bit until the lowest-index-first arbiter can push them.
module pulse_event_queue #(
    parameter int FIELDS = 4,
    parameter int DEPTH  = 8,
    localparam int IDW   = $clog2(FIELDS),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [FIELDS-1:0] pulses_in,
    output logic              event_valid_out,
    input  logic              event_ready_in,
    output logic [IDW-1:0]    event_id_out,
    output logic [CW-1:0]     count_out,
    output logic              overflow_out,
    input  logic              clear_overflow_in
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [FIELDS-1:0] pending;
    logic [FIELDS-1:0] lowest;
    logic [FIELDS-1:0] grant;
    logic [IDW-1:0]    grant_id;
    logic [IDW-1:0]    mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              push_ok;
    logic              push;
    logic              pop;
    logic              drop;

    assign pop     = (count != '0) & event_ready_in;
    // A full FIFO can still take a push when its head leaves on the same edge.
    assign push_ok = (count < FULL) | ((count == FULL) & pop);

    always_comb begin
        lowest = pending & (~pending + FIELDS'(1));
        grant  = push_ok ? lowest : '0;
    end

    assign push = |grant;
    assign drop = |(pulses_in & pending & ~grant);

    always_comb begin
        grant_id = '0;
        for (int i = 0; i < FIELDS; i++) begin
            if (lowest[i]) grant_id = IDW'(i);
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr] <= grant_id;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pending  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            // A pulse on a field being granted this cycle re-arms it rather than dropping.
            pending <= (pending & ~grant) | pulses_in;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop)                   overflow <= 1'b1;
            else if (clear_overflow_in) overflow <= 1'b0;
        end
    end

    assign event_valid_out = (count != '0);
    assign event_id_out    = mem[rd_ptr];
    assign count_out       = count;
    assign overflow_out    = overflow;

endmodule

// File: tb/tb_pulse_event_queue.sv
// Directed bench for pulse_event_queue: expected ids go into a scoreboard queue and a
// negedge monitor compares every consumed event; counts/flags are checked inline.
module tb_pulse_event_queue;

    localparam int FIELDS = 4;
    localparam int DEPTH  = 8;
    localparam int IDW    = $clog2(FIELDS);
    localparam int CW     = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [FIELDS-1:0] pulses;
    logic              valid;
    logic              ready;
    logic [IDW-1:0]    id;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              clear;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    pulse_event_queue #(.FIELDS(FIELDS), .DEPTH(DEPTH)) dut (
        .clk_in            (clk),
        .rst_n_in          (rst_n),
        .pulses_in         (pulses),
        .event_valid_out   (valid),
        .event_ready_in    (ready),
        .event_id_out      (id),
        .count_out         (count),
        .overflow_out      (overflow),
        .clear_overflow_in (clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every accepted event must match the next expected id.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid === 1'b1 && ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got id %0d, expected no event", id);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (id !== IDW'(e)) begin
                    errors++;
                    $display("FAIL event_id: got %0d, expected %0d", id, e);
                end
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        pulses = '0;
        ready  = 1'b0;
        clear  = 1'b0;
        #2;
        check("reset_valid", valid, 0);
        check("reset_count", count, 0);
        check("reset_overflow", overflow, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Single pulse on field 2: pending edge, then valid one cycle later.
        ready = 1'b1;
        pulses = 4'b0100; exp_q.push_back(2);
        tick();
        pulses = '0;
        check("t1_valid_pending", valid, 0);
        tick();
        check("t1_valid", valid, 1);
        check("t1_id", id, 2);
        check("t1_count_1", count, 1);
        tick();
        check("t1_count_0", count, 0);
        check("t1_overflow", overflow, 0);

        // Three fields at once drain in ascending order.
        pulses = 4'b1011; exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
        tick();
        pulses = '0;
        repeat (5) tick();
        check("t2_count", count, 0);
        check("t2_overflow", overflow, 0);

        // Fill the FIFO with ready low, then park extra events in pending.
        ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k % 2 == 0) begin
                pulses = FIELDS'(1 << ((k / 2) % 2));
                exp_q.push_back((k / 2) % 2);
            end else begin
                pulses = '0;
            end
            tick();
        end
        pulses = '0;
        check("t3_full_count", count, 8);
        pulses = 4'b0011; exp_q.push_back(0); exp_q.push_back(1);
        tick();
        pulses = '0;
        check("t3_full_pending_count", count, 8);
        check("t3_no_overflow_when_full", overflow, 0);
        pulses = 4'b0001;
        tick();
        pulses = '0;
        check("t3_drop_overflow", overflow, 1);
        check("t3_count_after_drop", count, 8);
        ready = 1'b1;
        tick();
        check("t4_pop_push_count", count, 8);
        ready = 1'b0;
        tick();
        check("t4_hold_count", count, 8);
        ready = 1'b1;
        repeat (12) tick();
        check("t3_drain_count", count, 0);
        check("t3_drain_queue_left", exp_q.size(), 0);

        // Clear alone drops the sticky flag.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t7_clear_alone", overflow, 0);

        // Drop and clear in the same cycle: set wins.
        pulses = 4'b0011; exp_q.push_back(0); exp_q.push_back(1);
        tick();
        pulses = 4'b0010; clear = 1'b1;
        tick();
        pulses = '0; clear = 1'b0;
        check("t7_set_wins", overflow, 1);
        repeat (4) tick();
        check("t7_count", count, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t7_clear_later", overflow, 0);

        // Re-pulse of a field in its grant cycle queues a second event.
        pulses = 4'b0010; exp_q.push_back(1);
        tick();
        pulses = 4'b0010; exp_q.push_back(1);
        tick();
        pulses = '0;
        check("t5_count_first", count, 1);
        check("t5_no_overflow", overflow, 0);
        tick();
        check("t5_count_second", count, 1);
        repeat (3) tick();
        check("t5_count_done", count, 0);
        check("t5_overflow_done", overflow, 0);

        // Build count=5 with overflow set, then async reset mid-cycle.
        ready = 1'b0;
        pulses = 4'b0001; tick();
        pulses = 4'b0001; tick();
        pulses = 4'b0001; tick();
        pulses = 4'b0011; tick();
        pulses = 4'b0010; tick();
        pulses = '0;      tick();
        check("t6_count_pre", count, 5);
        check("t6_overflow_pre", overflow, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_reset_valid", valid, 0);
        check("t6_reset_count", count, 0);
        check("t6_reset_overflow", overflow, 0);
        tick();
        rst_n = 1'b1;
        ready = 1'b1;
        pulses = 4'b1000; exp_q.push_back(3);
        tick();
        pulses = '0;
        check("t6_valid_pending", valid, 0);
        tick();
        check("t6_valid", valid, 1);
        check("t6_id", id, 3);
        check("t6_count_1", count, 1);
        tick();
        check("t6_count_0", count, 0);

        tick();
        check("final_queue_left", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_event_queue.md
Name: pulse_event_queue

Overview:
- Downstream consumer of the button pulser stage. Takes its per-field single-cycle pulses and turns them into a serialized stream of field-index events.
- Events are buffered in a small FIFO and presented to the simulator control logic over a valid/ready interface.
- A control FSM that is busy can therefore miss no button press. The one exception is a repeat press of a field that is still unqueued; that case is flagged.

Parameters:
- FIELDS, 4, number of pulse inputs. Must be ≥2.
- DEPTH, 8, FIFO entries. Must be a power of 2, ≥2.
- IDW, $clog2(FIELDS), width of the event index. Derived; do not override.
- CW, $clog2(DEPTH+1), width of the occupancy count. Derived; do not override.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  reset, asynchronous, active-low
- pulses_in  input  FIELDS  one-cycle pulses, one per field, from the pulser stage
- event_valid_out  output  1  head-of-queue event available
- event_ready_in  input  1  consumer accepts the head event
- event_id_out  output  IDW  field index of the head event
- count_out  output  CW  FIFO occupancy, 0..DEPTH
- overflow_out  output  1  sticky flag: at least one pulse was dropped
- clear_overflow_in  input  1  clears overflow_out

Behaviour:
- Reset: one clock, clk_in. Reset is asynchronous and active-low (rst_n_in). While rst_n_in=0, all of the following are zero: pending register, FIFO pointers, count_out, event_valid_out, overflow_out.
  - event_id_out during reset is don't-care. The bench checks it only when valid=1.
  - Deassertion is synchronous to clk_in, handled externally.
- Capture: each cycle, pending[i] <= (pending[i] & ~grant[i]) | pulses_in[i].
  - A level held high on pulses_in counts as one event per cycle.
- Drop: a pulse on field i while pending[i]=1 and grant[i]=0 is dropped. overflow_out goes to 1 at the next edge.
- Arbiter: fixed priority, lowest index wins. grant is one-hot of the lowest set pending bit, gated by push_ok. At most one push per cycle.
- push_ok = (count < DEPTH) | (count == DEPTH & pop). A full FIFO accepts a push in the same cycle it is popped.
- pop = event_valid_out & event_ready_in.
- FIFO storage:
  - Memory written at wr_ptr on push.
  - event_id_out = mem[rd_ptr], read combinationally.
  - event_valid_out = (count != 0).
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - count updates +1 on push-only, −1 on pop-only, unchanged on both or neither.
- Latency, empty queue, ready=1:
  - Pulse at cycle N sets pending at edge N.
  - Push at edge N+1.
  - event_valid_out high in cycle N+1.
  - Consumed at edge N+2.
- Ordering: FIFO order between pushes. Among fields pending together, ascending index.
- Grant and new pulse on the same field in the same cycle: pending stays 1. The new event is kept, not dropped.
- event_ready_in with count=0: ignored, with no pointer or count change.
- Overflow set and clear in the same cycle: set wins, overflow_out=1.
- Occupancy: overflow_out is not raised for a full FIFO by itself. Only dropped pulses raise it. Pulses wait in pending while the FIFO is full.
- Async reset mid-operation: queue flushed immediately. The first event after release follows normal latency.

Test Plan:
- Single pulse on field 2, ready=1 → valid=1 with id=2 exactly one cycle after the pending edge; count_out goes 0→1→0; overflow_out stays 0.
- pulses_in=4'b1011 in one cycle, ready=1 → ids 0, 1, 3 delivered on consecutive cycles; no overflow.
- ready=0, 8 pulses on alternating fields 0/1 across 16 cycles → count_out=8 with pending holding the rest.
  - Then a repeat pulse on pending field 0 → overflow_out=1.
  - Then raise ready → 8 events drain in push order, followed by the pending ones.
- FIFO full (count=8) with a pending event, ready=1 for one cycle → a pop and a push in the same edge; count_out stays 8.
- Pulse on field 1 in the same cycle it is granted → two id=1 events are queued; overflow_out=0.
- Assert rst_n_in low asynchronously mid-cycle with count=5 → valid, count and overflow read 0 before the next edge. After release, a pulse on field 3 yields id=3 with normal latency.
- clear_overflow_in=1 in the same cycle as a drop → overflow_out=1. Clear alone on a later cycle → 0.
